// File: rtl/cntr_seq_ctrl.sv
// Sequenced up/down counter with one-shot or auto-reload operation, pause/hold,
// abort and terminal-count pulse. Every output comes straight from a flop.
module cntr_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           st;
    logic             dir_q;
    logic             mode_q;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] reload_val;
    logic             at_term;

    // Up counts 0 -> limit; down counts limit -> 0.
    assign term_val   = dir_q ? '0 : lim_q;
    assign reload_val = dir_q ? lim_q : '0;
    assign at_term    = (count == term_val);
    assign state      = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            count  <= '0;
            tc     <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
            lim_q  <= '0;
        end else begin
            tc <= 1'b0;
            case (st)
                IDLE, DONE: begin
                    // stop wins over a simultaneous start
                    if (start && !stop) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        lim_q  <= load_val;
                        count  <= dir ? load_val : '0;
                        st     <= RUN;
                        done   <= 1'b0;
                        busy   <= 1'b1;
                    end else if (stop && (st == DONE)) begin
                        st    <= IDLE;
                        count <= '0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        st    <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        st <= HOLD;
                    end else if (tick) begin
                        if (at_term) begin
                            tc <= 1'b1;
                            if (mode_q) begin
                                count <= reload_val;
                            end else begin
                                st   <= DONE;
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end else begin
                            count <= dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        st    <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        st <= RUN;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Bench for cntr_seq_ctrl: directed scenarios plus randomized traffic, all
// checked against a step-position model of the counter sequence.
module tb_cntr_seq_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst, start, stop, pause, tick, dir, mode;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc, done, busy;
    logic [1:0]   state;

    int vectors = 0;
    int errors  = 0;

    // Model: m_k is the number of steps taken into the sequence.
    bit m_run, m_hold, m_fin, m_dir, m_auto, m_tc;
    int m_lim, m_k, m_cnt;

    always #5 clk = ~clk;

    cntr_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .tick(tick), .dir(dir), .mode(mode), .load_val(load_val),
        .count(count), .tc(tc), .done(done), .busy(busy), .state(state)
    );

    function automatic logic [8:0] exp_vec();
        int st;
        st = m_fin ? 3 : (!m_run ? 0 : (m_hold ? 2 : 1));
        return {2'(st), W'(m_cnt), m_tc, m_fin, m_run};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {state, count, tc, done, busy};
    endfunction

    task automatic model_update();
        m_tc = 1'b0;
        if (rst) begin
            m_run = 0; m_hold = 0; m_fin = 0; m_dir = 0; m_auto = 0;
            m_lim = 0; m_k = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (start && !stop) begin
                m_dir = dir; m_auto = mode; m_lim = int'(load_val);
                m_k = 0; m_run = 1; m_hold = 0; m_fin = 0;
            end else if (stop && m_fin) begin
                m_fin = 0; m_cnt = 0;
            end
        end else if (stop) begin
            m_run = 0; m_hold = 0; m_cnt = 0;
        end else if (m_hold) begin
            m_hold = pause;
        end else if (pause) begin
            m_hold = 1;
        end else if (tick) begin
            if (m_k == m_lim) begin
                m_tc = 1;
                if (m_auto) m_k = 0;
                else begin m_run = 0; m_fin = 1; end
            end else begin
                m_k++;
            end
        end
        if (m_run) m_cnt = m_dir ? (m_lim - m_k) : m_k;
    endtask

    task automatic drive(input bit r, input bit s, input bit sp, input bit pa,
                         input bit t, input bit d, input bit m, input int lv);
        @(negedge clk);
        rst = r; start = s; stop = sp; pause = pa; tick = t; dir = d; mode = m;
        load_val = W'(lv);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 1, 1, 1, $urandom_range(0, 15));
        step();
        vectors++;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state act=%b exp=00", state); end
        vectors++;
        if (count !== '0) begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
        vectors++;
        if ({tc, done, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags act=%b exp=000", {tc, done, busy});
        end
    endtask

    task automatic test_up_oneshot();
        int exp_c[4] = '{1, 2, 3, 3};
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, 0, 1, 0, 0, 3); step();
        vectors++;
        if (count !== 4'd0 || state !== 2'b01) begin
            errors++; $display("FAIL up_start act=%0d/%b exp=0/01", count, state);
        end
        drive(0, 0, 0, 0, 1, 1, 1, 9);
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (count !== W'(exp_c[i]) || tc !== (i == 3)) begin
                errors++; $display("FAIL up_seq[%0d] act=%0d tc=%b exp=%0d tc=%b", i, count, tc, exp_c[i], i == 3);
            end
        end
        vectors++;
        if (state !== 2'b11 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL up_done act=%b/%b/%b exp=11/1/0", state, done, busy);
        end
        step();
        vectors++;
        if (obs_vec() !== exp_vec() || count !== 4'd3 || tc !== 1'b0) begin
            errors++; $display("FAIL up_hold act=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_down_reload();
        int exp_c[6] = '{1, 0, 2, 1, 0, 2};
        drive(0, 1, 0, 0, 1, 1, 1, 2); step();
        vectors++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL down_start act=%0d busy=%b exp=2 busy=1", count, busy);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 7);
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (count !== W'(exp_c[i]) || tc !== (i % 3 == 2) || busy !== 1'b1 ||
                obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL down_seq[%0d] act=%0d tc=%b busy=%b exp=%0d tc=%b busy=1",
                                   i, count, tc, busy, exp_c[i], i % 3 == 2);
            end
        end
    endtask

    task automatic test_pause();
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, 0, 0, 0, 0, 9); step();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (state !== 2'b10 || count !== 4'd4) begin
                errors++; $display("FAIL pause_hold[%0d] act=%b/%0d exp=10/4", i, state, count);
            end
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0); step();
        vectors++;
        if (state !== 2'b01 || count !== 4'd4) begin
            errors++; $display("FAIL pause_release act=%b/%0d exp=01/4", state, count);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (count !== W'(5 + i)) begin
                errors++; $display("FAIL pause_resume[%0d] act=%0d exp=%0d", i, count, 5 + i);
            end
        end
    endtask

    task automatic test_stop();
        drive(0, 1, 0, 0, 0, 0, 0, 5); step();
        drive(0, 0, 0, 0, 1, 0, 0, 0); step(); step();
        drive(0, 0, 0, 1, 1, 0, 0, 0); step();
        drive(0, 0, 1, 1, 1, 0, 0, 0); step();
        vectors++;
        if (state !== 2'b00 || count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stop_hold act=%b/%0d/%b exp=00/0/0", state, count, tc);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 1, 0, 0, 0); step(); step();
        vectors++;
        if (state !== 2'b11 || tc !== 1'b1) begin
            errors++; $display("FAIL stop_reach_done act=%b tc=%b exp=11 tc=1", state, tc);
        end
        drive(0, 1, 1, 0, 1, 0, 0, 7); step();
        vectors++;
        if (state !== 2'b00 || count !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL stop_start_done act=%b/%0d/%b exp=00/0/0", state, count, tc);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0); step();
        vectors++;
        if (obs_vec() !== exp_vec() || state !== 2'b00) begin
            errors++; $display("FAIL stop_idle_stays act=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_lim();
        drive(0, 1, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 1, 1, 0, 5);
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (count !== 4'd0 || tc !== 1'b1 || state !== 2'b01) begin
                errors++; $display("FAIL zero_tick[%0d] act=%0d/%b/%b exp=0/1/01", i, count, tc, state);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        vectors++;
        if (tc !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL zero_notick act=%0d/%b exp=0/0", count, tc);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, 0, 0, 0, 0, 9); step();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (count !== 4'd5) begin errors++; $display("FAIL rstmid_pre act=%0d exp=5", count); end
        drive(1, 1, 0, 0, 1, 0, 0, 3); step();
        vectors++;
        if (state !== 2'b00 || count !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid act=%b/%0d/%b exp=00/0/0", state, count, busy);
        end
        drive(0, 1, 0, 0, 0, 1, 0, 3); step();
        vectors++;
        if (state !== 2'b01 || count !== 4'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_restart act=%b/%0d/%b exp=01/3/1", state, count, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15));
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] act st/cnt/tc/dn/bz=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0;
        dir = 1'b0; mode = 1'b0; load_val = '0;
        test_reset();
        test_up_oneshot();
        test_down_reload();
        test_pause();
        test_stop();
        test_zero_lim();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
